// File: rtl/iter_shift_unit.sv
// Iterative shift/rotate unit (SHL/SHR/SAR/ROL/ROR/RCL/RCR), one bit per cycle; ITER_SHIFT_FAST_EN enables up to 4 bits per cycle.
// Latency: count=N -> done N+1 cycles after the start edge (ceil(N/4)+1 with ITER_SHIFT_FAST_EN); count=0 or op=7 -> 1 cycle.
// Backpressure: start is accepted only in IDLE and ignored while busy; flush aborts to IDLE without a done pulse.
module iter_shift_unit #(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                flush,
    input  logic [2:0]          op,
    input  logic                is_8_bit,
    input  logic [WIDTH-1:0]    a,
    input  logic [CNT_BITS-1:0] count,
    input  logic [15:0]         flags_in,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    out,
    output logic [15:0]         flags_out
);

    localparam logic [2:0] OP_SHL = 3'd0, OP_SHR = 3'd1, OP_SAR = 3'd2, OP_ROL = 3'd3,
                           OP_ROR = 3'd4, OP_RCL = 3'd5, OP_RCR = 3'd6, OP_NOP = 3'd7;
`ifdef ITER_SHIFT_FAST_EN
    localparam int STEPS = 4;
`else
    localparam int STEPS = 1;
`endif
    localparam logic [WIDTH-1:0] MASK8 = WIDTH'(8'hFF);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    work, a_q;
    logic                cf_work;
    logic [CNT_BITS-1:0] remaining;
    logic [2:0]          op_q;
    logic                is8_q;
    logic [15:0]         flags_q;

    logic [WIDTH:0]      step_res;
    logic                last_step;
    logic [15:0]         flags_calc;
    logic [WIDTH-1:0]    a_masked;

    // One 1-bit step on the active width; bits above bit 7 stay zero in 8-bit mode.
    function automatic logic [WIDTH:0] step1(input logic [WIDTH-1:0] w, input logic c,
                                             input logic [2:0] o, input logic b8);
        logic             msb, top_in, nc;
        logic [WIDTH-1:0] r;
        msb    = b8 ? w[7] : w[WIDTH-1];
        r      = w;
        nc     = c;
        top_in = 1'b0;
        case (o)
            OP_SHL: begin nc = msb;  r = w << 1; end
            OP_SHR: begin nc = w[0]; r = w >> 1; end
            OP_SAR: begin nc = w[0]; r = w >> 1; top_in = msb;  end
            OP_ROL: begin nc = msb;  r = w << 1; r[0] = msb;    end
            OP_ROR: begin nc = w[0]; r = w >> 1; top_in = w[0]; end
            OP_RCL: begin nc = msb;  r = w << 1; r[0] = c;      end
            OP_RCR: begin nc = w[0]; r = w >> 1; top_in = c;    end
            default: ;
        endcase
        if (o == OP_SAR || o == OP_ROR || o == OP_RCR) begin
            if (b8) r[7] = top_in;
            else    r[WIDTH-1] = top_in;
        end
        if (b8) r = r & MASK8;
        return {nc, r};
    endfunction

    assign a_masked = is_8_bit ? (a & MASK8) : a;

    always_comb begin
        step_res = {cf_work, work};
        for (int i = 0; i < STEPS; i++) begin
            if (i < int'(remaining))
                step_res = step1(step_res[WIDTH-1:0], step_res[WIDTH], op_q, is8_q);
        end
        last_step = int'(remaining) <= STEPS;
    end

    // OF is judged against the captured operand and carry, not the intermediate steps.
    always_comb begin
        logic [WIDTH-1:0] rw;
        logic             a_msb, a_msb1, r_msb, of;
        rw     = step_res[WIDTH-1:0];
        a_msb  = is8_q ? a_q[7] : a_q[WIDTH-1];
        a_msb1 = is8_q ? a_q[6] : a_q[WIDTH-2];
        r_msb  = is8_q ? rw[7]  : rw[WIDTH-1];
        case (op_q)
            OP_SHL:         of = a_msb ^ r_msb;
            OP_SHR:         of = a_msb;
            OP_ROL, OP_RCL: of = a_msb ^ a_msb1;
            OP_ROR:         of = a_msb ^ a_q[0];
            OP_RCR:         of = a_msb ^ flags_q[0];
            default:        of = 1'b0;
        endcase
        flags_calc     = flags_q;
        flags_calc[0]  = step_res[WIDTH];
        flags_calc[2]  = ~^rw[7:0];
        flags_calc[6]  = (rw == '0);
        flags_calc[7]  = r_msb;
        flags_calc[11] = of;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (count == '0 || op == OP_NOP) ? DONE : SHIFT;
            SHIFT: if (last_step) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work      <= '0;
            cf_work   <= 1'b0;
            remaining <= '0;
            op_q      <= '0;
            is8_q     <= 1'b0;
            a_q       <= '0;
            flags_q   <= '0;
            out       <= '0;
            flags_out <= '0;
        end else if (!flush) begin
            if (state == IDLE && start) begin
                op_q      <= op;
                is8_q     <= is_8_bit;
                a_q       <= a_masked;
                flags_q   <= flags_in;
                work      <= a_masked;
                cf_work   <= flags_in[0];
                remaining <= count;
                if (count == '0 || op == OP_NOP) begin
                    out       <= a_masked;
                    flags_out <= flags_in;
                end
            end else if (state == SHIFT) begin
                work      <= step_res[WIDTH-1:0];
                cf_work   <= step_res[WIDTH];
                remaining <= remaining - CNT_BITS'(STEPS);
                if (last_step) begin
                    out       <= step_res[WIDTH-1:0];
                    flags_out <= flags_calc;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: latency, results, flags, flush and async reset.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        reset_n, start, flush, is_8_bit;
    logic [2:0]  op;
    logic [15:0] a, flags_in, out, flags_out;
    logic [4:0]  count;
    logic        busy, done;
    int          errors = 0;
    int          checks = 0;

    iter_shift_unit #(.WIDTH(16), .CNT_BITS(5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
        .is_8_bit(is_8_bit), .a(a), .count(count), .flags_in(flags_in),
        .busy(busy), .done(done), .out(out), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; starts the op and counts edges until done.
    task automatic run(input string tag, input logic [2:0] o, input logic b8, input logic [15:0] av,
                       input logic [4:0] cnt, input logic [15:0] fin, input int exp_lat,
                       input logic [15:0] exp_out, input logic [15:0] exp_fl, input bit noise);
        int n = 0;
        bit seen = 0;
        op = o; is_8_bit = b8; a = av; count = cnt; flags_in = fin; start = 1'b1;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = noise && (n == 3 || n == 7);
            if (start) begin op = 3'd0; a = 16'h5555; count = 5'd1; flags_in = 16'hFFFF; end
            seen = done;
        end
        start = 1'b0;
        chk($sformatf("%s_latency", tag), n, exp_lat);
        chk($sformatf("%s_out", tag), out, exp_out);
        chk($sformatf("%s_flags", tag), flags_out, exp_fl);
        @(posedge clk); #1;
        chk($sformatf("%s_done_pulse", tag), {busy, done}, 2'b00);
    endtask

    initial begin
        int fast_lat;
        bit saw_done;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; is_8_bit = 1'b0;
        a = '0; count = '0; flags_in = '0;
        #1;
        chk("reset_outputs", {busy, done, out, flags_out}, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run("shl16",      3'd0, 1'b0, 16'h8001, 5'd1,  16'h0000, 2,  16'h0002, 16'h0801, 1'b0);
        run("rcr8_c1",    3'd6, 1'b1, 16'hFF81, 5'd1,  16'h0000, 2,  16'h0040, 16'h0801, 1'b0);
        run("rcr8_c9",    3'd6, 1'b1, 16'h0081, 5'd9,  16'h0000, 10, 16'h0081, 16'h0884, 1'b0);
        run("sar16_c20",  3'd2, 1'b0, 16'h8000, 5'd20, 16'h0000, 21, 16'hFFFF, 16'h0085, 1'b1);
        run("rol_c0",     3'd3, 1'b0, 16'h1234, 5'd0,  16'h0ED5, 1,  16'h1234, 16'h0ED5, 1'b0);
`ifdef ITER_SHIFT_FAST_EN
        fast_lat = 4;
`else
        fast_lat = 11;
`endif
        run("ror16_c10",  3'd4, 1'b0, 16'h0001, 5'd10, 16'h0000, fast_lat, 16'h0040, 16'h0800, 1'b0);
        run("op7_pass",   3'd7, 1'b0, 16'hBEEF, 5'd5,  16'h0ED5, 1,  16'hBEEF, 16'h0ED5, 1'b0);
        run("shl8_c9",    3'd0, 1'b1, 16'h00FF, 5'd9,  16'h0010, 10, 16'h0000, 16'h0854, 1'b0);
        run("rol16_c17",  3'd3, 1'b0, 16'h8001, 5'd17, 16'h0000, 18, 16'h0003, 16'h0805, 1'b0);
        run("rcl8_c1",    3'd5, 1'b1, 16'h0080, 5'd1,  16'h0001, 2,  16'h0001, 16'h0801, 1'b0);
        run("shr16_c1",   3'd1, 1'b0, 16'h8001, 5'd1,  16'h0000, 2,  16'h4000, 16'h0805, 1'b0);

        // Flush after 3 cycles: back to IDLE, no done, outputs keep the SHR result above.
        op = 3'd1; is_8_bit = 1'b0; a = 16'hF0F0; count = 5'd10; flags_in = 16'h0000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_idle", {busy, done}, 2'b00);
        chk("flush_out_held", out, 16'h4000);
        chk("flush_flags_held", flags_out, 16'h0805);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("flush_no_done", saw_done, 1'b0);

        // Async reset mid-operation clears outputs without waiting for a clock edge.
        op = 3'd0; a = 16'h1234; count = 5'd10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, out, flags_out}, '0);
        @(posedge clk); #1 reset_n = 1'b1;

        run("ror8_after_reset", 3'd4, 1'b1, 16'h0001, 5'd1, 16'h0000, 2, 16'h0080, 16'h0881, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
